// File: rtl/multi_light_shader_pkg.sv
// Shared types, widths and helpers for the multi-light diffuse shader.
package multi_light_shader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIT   = 3'd1,
        ST_LIGHT = 3'd2,
        ST_COLOR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;
    localparam logic [3:0] INTENSITY_MAX = 4'd15;

    // Hit point = origin + dir*t without truncation.
    function automatic int hit_w(input int coord_w, input int t_w);
        return coord_w + t_w + 2;
    endfunction

    // normal (coord_w) times L (hit_w+1), summed over three components.
    function automatic int dot_w(input int coord_w, input int hw);
        return coord_w + hw + 1 + 2;
    endfunction

    function automatic logic [3:0] sat4(input logic [4:0] v);
        return (v > 5'd15) ? INTENSITY_MAX : v[3:0];
    endfunction

    // (base*I + 15) >> 4, exact over 0..15 x 0..15
    function automatic logic [3:0] shade_ch(input logic [3:0] base, input logic [3:0] inten);
        logic [8:0] p;
        p = ({5'd0, base} * {5'd0, inten}) + 9'd15;
        return 4'(p >> 4);
    endfunction

endpackage

// File: rtl/multi_light_shader_if.sv
// Request/response bundle between intersection stage, shader and framebuffer writer.
interface multi_light_shader_if #(
    parameter int NUM_LIGHTS = 2,
    parameter int COORD_W    = 11,
    parameter int T_W        = 10
) ();
    logic                              in_valid;
    logic                              in_ready;
    logic [3*COORD_W-1:0]              init;
    logic [3*COORD_W-1:0]              dir;
    logic [T_W-1:0]                    t;
    logic [3*COORD_W-1:0]              normal;
    logic [4:0]                        norm_shift;
    logic [11:0]                       base_color;
    logic [NUM_LIGHTS*3*COORD_W-1:0]   light_pos;
    logic [NUM_LIGHTS-1:0]             light_en;
    logic                              out_valid;
    logic                              out_ready;
    logic [11:0]                       color;

    modport master (
        output in_valid, init, dir, t, normal, norm_shift, base_color, light_pos, light_en, out_ready,
        input  in_ready, out_valid, color
    );

    modport slave (
        input  in_valid, init, dir, t, normal, norm_shift, base_color, light_pos, light_en, out_ready,
        output in_ready, out_valid, color
    );
endinterface

// File: rtl/multi_light_shader_lambert_term.sv
// Combinational clamped Lambert term for one point light: L = light - hit, n.L, shift, saturate to 4 bits.
module lambert_term
    import multi_light_shader_pkg::*;
#(
    parameter int COORD_W = 11,
    parameter int HIT_W   = 23,
    parameter int DOT_W   = 37
) (
    input  logic [3*COORD_W-1:0] light,
    input  logic [3*HIT_W-1:0]   hit,
    input  logic [3*COORD_W-1:0] normal,
    input  logic [4:0]           norm_shift,
    input  logic                 en,
    output logic [3:0]           term
);

    logic [COORD_W-1:0] p_s;
    logic [COORD_W-1:0] n_s;
    logic [HIT_W-1:0]   h_s;
    logic [DOT_W-1:0]   l_s;
    logic [DOT_W-1:0]   dot_s;
    logic [DOT_W-1:0]   shifted_s;

    // Two's-complement dot product evaluated at full DOT_W, then clamp and saturate.
    always_comb begin
        p_s   = '0;
        n_s   = '0;
        h_s   = '0;
        l_s   = '0;
        dot_s = '0;
        for (int k = 0; k < 3; k++) begin
            p_s   = light[(3-k)*COORD_W-1 -: COORD_W];
            n_s   = normal[(3-k)*COORD_W-1 -: COORD_W];
            h_s   = hit[(3-k)*HIT_W-1 -: HIT_W];
            l_s   = {{(DOT_W-COORD_W){p_s[COORD_W-1]}}, p_s} - {{(DOT_W-HIT_W){h_s[HIT_W-1]}}, h_s};
            dot_s = dot_s + ({{(DOT_W-COORD_W){n_s[COORD_W-1]}}, n_s} * l_s);
        end
        shifted_s = $signed(dot_s) >>> norm_shift;
        if (!en || dot_s[DOT_W-1] || (dot_s == {DOT_W{1'b0}})) begin
            term = 4'd0;
        end else if (shifted_s > DOT_W'(15)) begin
            term = INTENSITY_MAX;
        end else begin
            term = shifted_s[3:0];
        end
    end

endmodule

// File: rtl/multi_light_shader.sv
// N-light diffuse shader: hit point, per-light Lambert accumulation, RGB444 output.
// Optional ambient floor via `SHADER_AMBIENT_EN.
module multi_light_shader
    import multi_light_shader_pkg::*;
#(
    parameter int         NUM_LIGHTS  = 2,
    parameter int         COORD_W     = 11,
    parameter int         T_W         = 10,
    parameter logic [3:0] AMBIENT_LVL = 4'd2
) (
    input logic                    clk,
    input logic                    rst,
    multi_light_shader_if.slave    bus
);

    localparam int CW3   = 3 * COORD_W;
    localparam int HIT_W = hit_w(COORD_W, T_W);
    localparam int DOT_W = dot_w(COORD_W, HIT_W);
    localparam int IDX_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
`ifdef SHADER_AMBIENT_EN
    localparam logic [3:0] ACC_INIT = AMBIENT_LVL;
`else
    localparam logic [3:0] ACC_INIT = AMBIENT_LVL & 4'd0;
`endif

    state_e                          state_r, state_s;
    logic [IDX_W-1:0]                idx_r;
    logic [3:0]                      acc_r;
    logic [CW3-1:0]                  init_r, dir_r, normal_r;
    logic [T_W-1:0]                  t_r;
    logic [4:0]                      shift_r;
    logic [11:0]                     base_r;
    logic [NUM_LIGHTS*CW3-1:0]       light_pos_r;
    logic [NUM_LIGHTS-1:0]           light_en_r;
    logic [3*HIT_W-1:0]              hit_r, hit_s;
    logic [11:0]                     color_r;
    logic [CW3-1:0]                  light_sel_s;
    logic                            en_sel_s;
    logic                            last_s;
    logic [3:0]                      term_s;
    logic [COORD_W-1:0]              ic_s, dc_s;

    // Hit point per component: origin + dir*t, sign-extended to HIT_W.
    always_comb begin
        hit_s = '0;
        ic_s  = '0;
        dc_s  = '0;
        for (int k = 0; k < 3; k++) begin
            ic_s = init_r[(3-k)*COORD_W-1 -: COORD_W];
            dc_s = dir_r[(3-k)*COORD_W-1 -: COORD_W];
            hit_s[(3-k)*HIT_W-1 -: HIT_W] = {{(HIT_W-COORD_W){ic_s[COORD_W-1]}}, ic_s}
                + ({{(HIT_W-COORD_W){dc_s[COORD_W-1]}}, dc_s} * {{(HIT_W-T_W){1'b0}}, t_r});
        end
    end

    // Current-light select and end-of-sweep detect.
    always_comb begin
        light_sel_s = light_pos_r[32'(idx_r) * CW3 +: CW3];
        en_sel_s    = light_en_r[idx_r];
        last_s      = (idx_r == IDX_W'(NUM_LIGHTS - 1));
    end

    lambert_term #(
        .COORD_W (COORD_W),
        .HIT_W   (HIT_W),
        .DOT_W   (DOT_W)
    ) u_lambert (
        .light      (light_sel_s),
        .hit        (hit_r),
        .normal     (normal_r),
        .norm_shift (shift_r),
        .en         (en_sel_s),
        .term       (term_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (bus.in_valid) state_s = ST_HIT;   else state_s = ST_IDLE;
            ST_HIT:   state_s = ST_LIGHT;
            ST_LIGHT: if (last_s)       state_s = ST_COLOR; else state_s = ST_LIGHT;
            ST_COLOR: state_s = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_s = ST_IDLE; else state_s = ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register; colour comes straight from its flop.
    always_comb begin
        bus.in_ready  = (state_r == ST_IDLE);
        bus.out_valid = (state_r == ST_DONE);
        bus.color     = color_r;
    end

    // Datapath: capture on accept, hit, per-light accumulate, colour register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r       <= {IDX_W{1'b0}};
            acc_r       <= 4'd0;
            init_r      <= '0;
            dir_r       <= '0;
            normal_r    <= '0;
            t_r         <= '0;
            shift_r     <= 5'd0;
            base_r      <= 12'h000;
            light_pos_r <= '0;
            light_en_r  <= '0;
            hit_r       <= '0;
            color_r     <= 12'h000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        init_r      <= bus.init;
                        dir_r       <= bus.dir;
                        normal_r    <= bus.normal;
                        t_r         <= bus.t;
                        shift_r     <= bus.norm_shift;
                        base_r      <= bus.base_color;
                        light_pos_r <= bus.light_pos;
                        light_en_r  <= bus.light_en;
                    end
                end
                ST_HIT: begin
                    hit_r <= hit_s;
                    acc_r <= ACC_INIT;
                    idx_r <= {IDX_W{1'b0}};
                end
                ST_LIGHT: begin
                    acc_r <= sat4({1'b0, acc_r} + {1'b0, term_s});
                    idx_r <= last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
                end
                ST_COLOR: begin
                    color_r <= {shade_ch(base_r[R_LSB+3 -: 4], acc_r),
                                shade_ch(base_r[G_LSB+3 -: 4], acc_r),
                                shade_ch(base_r[B_LSB+3 -: 4], acc_r)};
                end
                default: begin
                    color_r <= color_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_light_shader.sv
// Self-checking bench: randomized requests against a cycle-level behavioural model plus pinned literal cases.
module tb_multi_light_shader;

    localparam int N  = 2;
    localparam int C  = 11;
    localparam int TW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_light_shader_if #(.NUM_LIGHTS(N), .COORD_W(C), .T_W(TW)) bus ();

    multi_light_shader #(.NUM_LIGHTS(N), .COORD_W(C), .T_W(TW), .AMBIENT_LVL(4'd2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int ncyc    = 0;
    int acc_cyc = 0;
    int hs_cyc  = 0;
    bit done    = 1'b0;

    always @(negedge clk) ncyc <= ncyc + 1;

    function automatic longint comp(input logic [3*C-1:0] v, input int k);
        logic signed [C-1:0] s;
        s = v[(2-k)*C +: C];
        return longint'(s);
    endfunction

    // Reference shading straight from the arithmetic definition.
    function automatic logic [11:0] ref_color(input logic [3*C-1:0] ini, input logic [3*C-1:0] dr,
                                              input logic [3*C-1:0] nr, input logic [TW-1:0] tt,
                                              input logic [4:0] sh, input logic [11:0] bc,
                                              input logic [N*3*C-1:0] lp, input logic [N-1:0] en);
        longint h[3];
        longint d, term, inten, b;
        logic [3*C-1:0] lv;
        logic [11:0] res;
        inten = 0;
        res = 12'h000;
        for (int k = 0; k < 3; k++) h[k] = comp(ini, k) + comp(dr, k) * longint'(tt);
        for (int i = 0; i < N; i++) begin
            lv = lp[i*3*C +: 3*C];
            d = 0;
            for (int k = 0; k < 3; k++) d += comp(nr, k) * (comp(lv, k) - h[k]);
            term = 0;
            if (en[i] && d > 0) term = ((d >>> sh) > 15) ? 15 : (d >>> sh);
            inten = (inten + term > 15) ? 15 : inten + term;
        end
        for (int c = 0; c < 3; c++) begin
            b = longint'(bc[(2-c)*4 +: 4]);
            res[(2-c)*4 +: 4] = 4'((b * inten + 15) / 16);
        end
        return res;
    endfunction

    // Behavioural timing model: result appears N+2 edges after the accept edge, held until taken.
    bit          m_busy, m_valid;
    int          m_count;
    logic [11:0] m_color, m_pending;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_count <= 0; m_color <= 12'h000;
        end else if (m_valid) begin
            if (bus.out_ready) begin m_valid <= 1'b0; m_busy <= 1'b0; end
        end else if (m_busy) begin
            if (m_count == N + 1) begin m_valid <= 1'b1; m_color <= m_pending; end
            m_count <= m_count + 1;
        end else if (bus.in_valid) begin
            m_busy    <= 1'b1;
            m_count   <= 0;
            m_pending <= ref_color(bus.init, bus.dir, bus.normal, bus.t, bus.norm_shift,
                                   bus.base_color, bus.light_pos, bus.light_en);
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                vectors++;
                if (bus.in_ready !== !m_busy) begin
                    errors++; $display("FAIL in_ready @%0d: got %b expected %b", ncyc, bus.in_ready, !m_busy);
                end
                if (bus.out_valid !== m_valid) begin
                    errors++; $display("FAIL out_valid @%0d: got %b expected %b", ncyc, bus.out_valid, m_valid);
                end
                if (bus.color !== m_color) begin
                    errors++; $display("FAIL color @%0d: got %h expected %h", ncyc, bus.color, m_color);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++; $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3*C-1:0] v3(input int x, input int y, input int z);
        return {11'(x), 11'(y), 11'(z)};
    endfunction

    function automatic logic [C-1:0] rc();
        if ($urandom_range(0, 3) == 0) return 11'($urandom);
        return 11'(int'($urandom_range(0, 127)) - 64);
    endfunction

    task automatic scramble();
        bus.init       = {rc(), rc(), rc()};
        bus.dir        = {rc(), rc(), rc()};
        bus.normal     = {rc(), rc(), rc()};
        bus.t          = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 40));
        bus.norm_shift = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
        bus.base_color = 12'($urandom);
        bus.light_pos  = {rc(), rc(), rc(), rc(), rc(), rc()};
        bus.light_en   = 2'($urandom);
    endtask

    // One full transaction; caller is aligned just after a falling edge.
    task automatic do_req(input logic [3*C-1:0] ini, input logic [3*C-1:0] dr, input logic [3*C-1:0] nr,
                          input logic [TW-1:0] tt, input logic [4:0] sh, input logic [11:0] bc,
                          input logic [N*3*C-1:0] lp, input logic [N-1:0] en, input int hold,
                          input bit junk, input bit lit_en, input logic [11:0] lit, input bit lat_en);
        int n, w;
        bit got;
        bus.init = ini; bus.dir = dr; bus.normal = nr; bus.t = tt; bus.norm_shift = sh;
        bus.base_color = bc; bus.light_pos = lp; bus.light_en = en; bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(negedge clk); #1; w++; end
        if (!bus.in_ready) begin
            vectors++; errors++; $display("FAIL accept_timeout: in_ready got 0 expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk); n++; got = bus.out_valid; #1;
            if (n == 1) begin scramble(); bus.in_valid = 1'b0; acc_cyc = ncyc; end
        end
        bus.in_valid = 1'b0;
        check("out_valid_timeout", 32'(got), 32'd1);
        if (lat_en) check("latency", 32'(n), 32'(N + 3));
        if (lit_en) check("color_literal", 32'(bus.color), 32'(lit));
        repeat (hold) begin
            if (junk) begin scramble(); bus.in_valid = 1'b1; end
            @(negedge clk); #1;
        end
        if (lit_en && hold > 0) check("color_held", 32'(bus.color), 32'(lit));
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk); #1;
        bus.out_ready = 1'b0;
        hs_cyc = ncyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3*C-1:0] o, d1, nm;
        int hs_before;
        o  = v3(0, 0, 0);
        d1 = v3(1, 1, 0);
        nm = v3(-1, -1, 0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_color", 32'(bus.color), 32'h000);
        rst = 1'b1;
        @(negedge clk); #1;

        do_req(o, d1, nm, 10'd19, 5'd1, 12'hF80, {v3(5, 5, 5), v3(0, 0, 0)}, 2'b01, 0, 0, 1, 12'hF80, 1);
        do_req(o, d1, nm, 10'd19, 5'd1, 12'hF80, {v3(5, 5, 5), v3(40, 40, 0)}, 2'b01, 0, 0, 1, 12'h000, 1);
        do_req(o, d1, nm, 10'd19, 5'd1, 12'hFFF, {v3(10, 10, 0), v3(10, 10, 0)}, 2'b11, 0, 0, 1, 12'hFFF, 0);
        do_req(o, d1, nm, 10'd19, 5'd1, 12'hFFF, {v3(10, 10, 0), v3(10, 10, 0)}, 2'b01, 0, 0, 1, 12'h999, 0);
        do_req(o, d1, nm, 10'd19, 5'd1, 12'hF80, {v3(5, 5, 5), v3(0, 0, 0)}, 2'b01, 10, 1, 1, 12'hF80, 1);
        hs_before = hs_cyc;
        do_req(o, d1, nm, 10'd19, 5'd1, 12'hF80, {v3(0, 0, 0), v3(0, 0, 0)}, 2'b00, 0, 0, 1, 12'h000, 1);
        check("back_to_back_gap", 32'(acc_cyc - hs_before), 32'd1);

        // Reset while the light sweep is in progress.
        bus.init = o; bus.dir = d1; bus.normal = nm; bus.t = 10'd19; bus.norm_shift = 5'd1;
        bus.base_color = 12'hFFF; bus.light_pos = {v3(0, 0, 0), v3(0, 0, 0)}; bus.light_en = 2'b11;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        do_req(o, d1, nm, 10'd19, 5'd1, 12'hF80, {v3(5, 5, 5), v3(0, 0, 0)}, 2'b01, 0, 0, 1, 12'hF80, 1);

        for (int r = 0; r < 200; r++) begin
            scramble();
            do_req(bus.init, bus.dir, bus.normal, bus.t, bus.norm_shift, bus.base_color, bus.light_pos,
                   bus.light_en, int'($urandom_range(0, 3)), 1'($urandom), 0, 12'h000, 1);
        end

        repeat (2) @(negedge clk);
        done = 1'b1;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
